rule_pg_filter: RTL and testbench

//  Parametrised rule-to-port-group filter with valid/ready flow control. Takes candidate rule IDs

---
 rtl/rule_pg_pkg.sv | 18 +
 rtl/rule_pg_fifo.sv | 46 ++++
 rtl/rule_pg_filter.sv | 156 +++++++++++++++
 tb/tb_rule_pg_filter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rule_pg_pkg.sv
// Shared defaults, types and latency helper for the rule-to-port-group filter.
package rule_pg_pkg;

    localparam int RULE_AW_DEF    = 13;
    localparam int PG_AW_DEF      = 9;
    localparam int NUM_PG_DEF     = 4;
    localparam int R2PG_LAT_DEF   = 2;
    localparam int MATCH_LAT_DEF  = 8;
    localparam int FIFO_DEPTH_DEF = 32;

    typedef logic [NUM_PG_DEF-1:0][PG_AW_DEF-1:0] pg_slots_t;

    // Accept-to-lane_match latency; the FIFO push happens on the edge after.
    function automatic int pipe_lat(input int r2pg_lat, input int match_lat);
        return r2pg_lat + 2 + match_lat;
    endfunction

endpackage

// File: rtl/rule_pg_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count for matched rules.
module rule_pg_fifo
    import rule_pg_pkg::*;
#(
    parameter int WIDTH = RULE_AW_DEF + NUM_PG_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // NOTE: storage is not reset; pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/rule_pg_filter.sv
// Rule-to-port-group filter: rule2pg lookup, per-lane port-group checks, credit-gated output FIFO.
// Optional RULE_PG_FILTER_STATS_EN adds saturating match/drop/stall counters.
module rule_pg_filter
    import rule_pg_pkg::*;
#(
    parameter int RULE_AW    = RULE_AW_DEF,
    parameter int PG_AW      = PG_AW_DEF,
    parameter int NUM_PG     = NUM_PG_DEF,
    parameter int R2PG_LAT   = R2PG_LAT_DEF,
    parameter int MATCH_LAT  = MATCH_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RULE_AW-1:0]      in_rule,
    input  logic [15:0]             in_src_port,
    input  logic [15:0]             in_dst_port,
    input  logic                    in_tcp,
    output logic                    r2pg_rd,
    output logic [RULE_AW-1:0]      r2pg_addr,
    input  logic [NUM_PG*PG_AW-1:0] r2pg_data,
    output logic [NUM_PG-1:0]       lane_req_valid,
    output logic [NUM_PG*PG_AW-1:0] lane_req_pg,
    output logic [15:0]             lane_src_port,
    output logic [15:0]             lane_dst_port,
    output logic                    lane_tcp,
    input  logic [NUM_PG-1:0]       lane_match,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [RULE_AW-1:0]      out_rule,
    output logic [NUM_PG-1:0]       out_pg_mask
`ifdef RULE_PG_FILTER_STATS_EN
    ,
    output logic [31:0]             stat_match_cnt,
    output logic [31:0]             stat_drop_cnt,
    output logic [31:0]             stat_stall_cnt
`endif
);

    localparam int PIPE_LAT = pipe_lat(R2PG_LAT, MATCH_LAT);
    localparam int CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int DEC      = R2PG_LAT + 1;

    typedef logic [NUM_PG-1:0][PG_AW-1:0] slots_t;

    if (FIFO_DEPTH < PIPE_LAT + 2) begin : g_depth_check
        $error("rule_pg_filter: FIFO_DEPTH must be at least PIPE_LAT+2");
    end

    logic                      w_accept;
    logic                      w_retire;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_fifo_empty;
    logic [CW-1:0]             w_fifo_count;
    logic [RULE_AW+NUM_PG-1:0] w_fifo_dout;
    logic [NUM_PG-1:0]         w_slot_vld;
    logic [NUM_PG-1:0]         w_hit;

    logic [CW-1:0]             r_inflight;
    logic [PIPE_LAT:1]         r_vld;
    logic [RULE_AW-1:0]        r_rule [1:PIPE_LAT];
    logic [15:0]               r_src  [1:DEC];
    logic [15:0]               r_dst  [1:DEC];
    logic [DEC:1]              r_tcp;
    slots_t                    r_slots;
    logic [NUM_PG-1:0]         r_mask [1:MATCH_LAT];

    // Credits cover every accepted rule that might still land in the FIFO.
    assign in_ready  = ~rst & ((CW'(FIFO_DEPTH) - w_fifo_count) > r_inflight);
    assign w_accept  = in_valid & in_ready & (in_rule != '0);
    assign r2pg_rd   = w_accept;
    assign r2pg_addr = in_rule - RULE_AW'(1);

    always_comb begin
        w_slot_vld = '0;
        for (int k = 0; k < NUM_PG; k++) w_slot_vld[k] = (r_slots[k] != '0);
    end

    assign w_hit    = lane_match & r_mask[MATCH_LAT];
    assign w_retire = r_vld[PIPE_LAT];
    assign w_push   = w_retire & (|w_hit);
    assign w_pop    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld          <= '0;
            r_inflight     <= '0;
            lane_req_valid <= '0;
        end else begin
            r_vld          <= {r_vld[PIPE_LAT-1:1], w_accept};
            r_inflight     <= r_inflight + CW'(w_accept) - CW'(w_retire);
            lane_req_valid <= w_slot_vld & {NUM_PG{r_vld[DEC]}};
        end
    end

    // Payload pipes carry no reset; only the valid pipe decides what is live.
    always_ff @(posedge clk) begin
        r_rule[1] <= in_rule;
        for (int k = 2; k <= PIPE_LAT; k++) r_rule[k] <= r_rule[k-1];
        r_src[1] <= in_src_port;
        r_dst[1] <= in_dst_port;
        for (int k = 2; k <= DEC; k++) begin
            r_src[k] <= r_src[k-1];
            r_dst[k] <= r_dst[k-1];
        end
        r_tcp   <= {r_tcp[DEC-1:1], in_tcp};
        r_slots <= r2pg_data;
        for (int k = 0; k < NUM_PG; k++) lane_req_pg[k*PG_AW +: PG_AW] <= r_slots[k] - PG_AW'(1);
        lane_src_port <= r_src[DEC];
        lane_dst_port <= r_dst[DEC];
        lane_tcp      <= r_tcp[DEC];
        r_mask[1] <= lane_req_valid;
        for (int k = 2; k <= MATCH_LAT; k++) r_mask[k] <= r_mask[k-1];
    end

    rule_pg_fifo #(
        .WIDTH (RULE_AW + NUM_PG),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({r_rule[PIPE_LAT], w_hit}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign out_valid   = ~w_fifo_empty;
    assign out_rule    = w_fifo_dout[RULE_AW+NUM_PG-1:NUM_PG];
    assign out_pg_mask = w_fifo_dout[NUM_PG-1:0];

`ifdef RULE_PG_FILTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_match_cnt <= '0;
            stat_drop_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (w_push && (stat_match_cnt != '1))
                stat_match_cnt <= stat_match_cnt + 32'd1;
            if (w_retire && !w_push && (stat_drop_cnt != '1))
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            if (in_valid && !in_ready && (stat_stall_cnt != '1))
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
        end
    end
`else
    // Statistics build option off: no counters exist and the datapath is unchanged.
`endif

endmodule

// File: tb/tb_rule_pg_filter.sv
// Directed self-checking bench for rule_pg_filter with behavioural rule2pg memory and lane matchers.
module tb_rule_pg_filter;
    import rule_pg_pkg::*;

    localparam int RULE_AW   = RULE_AW_DEF;
    localparam int PG_AW     = PG_AW_DEF;
    localparam int NUM_PG    = NUM_PG_DEF;
    localparam int R2PG_LAT  = R2PG_LAT_DEF;
    localparam int MATCH_LAT = MATCH_LAT_DEF;
    localparam int DEPTH     = FIFO_DEPTH_DEF;
    localparam int PIPE_LAT  = R2PG_LAT + 2 + MATCH_LAT;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [RULE_AW-1:0]      in_rule;
    logic [15:0]             in_src_port;
    logic [15:0]             in_dst_port;
    logic                    in_tcp;
    logic                    r2pg_rd;
    logic [RULE_AW-1:0]      r2pg_addr;
    logic [NUM_PG*PG_AW-1:0] r2pg_data;
    logic [NUM_PG-1:0]       lane_req_valid;
    logic [NUM_PG*PG_AW-1:0] lane_req_pg;
    logic [15:0]             lane_src_port;
    logic [15:0]             lane_dst_port;
    logic                    lane_tcp;
    logic [NUM_PG-1:0]       lane_match;
    logic                    out_valid;
    logic                    out_ready;
    logic [RULE_AW-1:0]      out_rule;
    logic [NUM_PG-1:0]       out_pg_mask;

    int checks   = 0;
    int failures = 0;

    pg_slots_t r2pg_tab [1 << RULE_AW];
    logic      pg_allow [1 << PG_AW];
    logic [RULE_AW+NUM_PG-1:0] exp_q [$];

    always #5 clk = ~clk;

    rule_pg_filter dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rule        (in_rule),
        .in_src_port    (in_src_port),
        .in_dst_port    (in_dst_port),
        .in_tcp         (in_tcp),
        .r2pg_rd        (r2pg_rd),
        .r2pg_addr      (r2pg_addr),
        .r2pg_data      (r2pg_data),
        .lane_req_valid (lane_req_valid),
        .lane_req_pg    (lane_req_pg),
        .lane_src_port  (lane_src_port),
        .lane_dst_port  (lane_dst_port),
        .lane_tcp       (lane_tcp),
        .lane_match     (lane_match),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_rule       (out_rule),
        .out_pg_mask    (out_pg_mask)
    );

    // rule2pg memory: two-cycle address-to-data latency
    logic [RULE_AW-1:0] mem_a1 = '0;
    logic [RULE_AW-1:0] mem_a2 = '0;
    always @(posedge clk) begin
        mem_a1 <= r2pg_addr;
        mem_a2 <= mem_a1;
    end
    assign r2pg_data = r2pg_tab[mem_a2];

    // Lane matchers answer every lane (requested or not); the filter must mask unused slots.
    logic [NUM_PG-1:0] m_req;
    logic [NUM_PG-1:0] m_pipe [1:MATCH_LAT];
    always_comb begin
        m_req = '0;
        for (int k = 0; k < NUM_PG; k++)
            m_req[k] = pg_allow[lane_req_pg[k*PG_AW +: PG_AW]] ^ lane_dst_port[0];
    end
    always @(posedge clk) begin
        m_pipe[1] <= m_req;
        for (int k = 2; k <= MATCH_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
    assign lane_match = m_pipe[MATCH_LAT];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [NUM_PG-1:0] exp_mask(input logic [RULE_AW-1:0] rule,
                                                   input logic [15:0] dst);
        pg_slots_t         s;
        logic [NUM_PG-1:0] m;
        s = r2pg_tab[rule - RULE_AW'(1)];
        m = '0;
        for (int k = 0; k < NUM_PG; k++)
            if (s[k] != '0) m[k] = pg_allow[s[k] - PG_AW'(1)] ^ dst[0];
        return m;
    endfunction

    // One clock of stimulus; scoreboard records accepts and checks pops.
    task automatic cycle(input logic v, input logic [RULE_AW-1:0] rule, input logic [15:0] dst,
                         input logic rdy, output logic acc);
        logic [RULE_AW+NUM_PG-1:0] e;
        logic [NUM_PG-1:0]         m;
        in_valid    = v;
        in_rule     = rule;
        in_src_port = 16'h1000 ^ 16'(rule);
        in_dst_port = dst;
        in_tcp      = dst[1];
        out_ready   = rdy;
        #1;
        acc = v & in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_rule", 32'(out_rule), 32'(e[RULE_AW+NUM_PG-1:NUM_PG]));
                check("out_mask", 32'(out_pg_mask), 32'(e[NUM_PG-1:0]));
            end
        end
        if (acc && rule != '0) begin
            m = exp_mask(rule, dst);
            if (m != '0) exp_q.push_back({rule, m});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic acc;
        int   guard;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 400) begin
            cycle(1'b0, '0, 16'h0, 1'b1, acc);
            guard++;
        end
        repeat (PIPE_LAT + 2) cycle(1'b0, '0, 16'h0, 1'b1, acc);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pg_slots_t s;
        logic      acc;
        int        idx;
        int        guard;

        for (int i = 0; i < (1 << RULE_AW); i++) r2pg_tab[i] = '0;
        for (int i = 0; i < (1 << PG_AW); i++) pg_allow[i] = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_rule = 13'd5; in_src_port = '0;
        in_dst_port = '0; in_tcp = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_r2pg_rd", 32'(r2pg_rd), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_lane_req", 32'(lane_req_valid), 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        tick(0);

        // Test 1: rule 5, slot0 = pg3, lane0 matches; exact latencies
        s = '0; s[0] = 9'd3; r2pg_tab[4] = s;
        pg_allow[2] = 1'b1;
        in_valid = 1'b1; in_rule = 13'd5; in_src_port = 16'd1234; in_dst_port = 16'd80; in_tcp = 1'b1;
        #1;
        check("t1_r2pg_rd", 32'(r2pg_rd), 32'd1);
        check("t1_r2pg_addr", 32'(r2pg_addr), 32'd4);
        tick(1);
        in_valid = 1'b0;
        tick(R2PG_LAT);
        check("t1_req_early", 32'(lane_req_valid), 32'd0);
        tick(1);
        check("t1_req_valid", 32'(lane_req_valid), 32'b0001);
        check("t1_req_pg0", 32'(lane_req_pg[PG_AW-1:0]), 32'd2);
        check("t1_lane_src", 32'(lane_src_port), 32'd1234);
        check("t1_lane_dst", 32'(lane_dst_port), 32'd80);
        check("t1_lane_tcp", 32'(lane_tcp), 32'd1);
        tick(MATCH_LAT);
        check("t1_out_early", 32'(out_valid), 32'd0);
        tick(1);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_rule", 32'(out_rule), 32'd5);
        check("t1_out_mask", 32'(out_pg_mask), 32'b0001);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t1_popped", 32'(out_valid), 32'd0);

        // Test 2: rule 0 consumed without a read; rule 7 has no valid slot
        in_valid = 1'b1; in_rule = '0; in_dst_port = 16'd80;
        #1;
        check("t2_rule0_ready", 32'(in_ready), 32'd1);
        check("t2_rule0_rd", 32'(r2pg_rd), 32'd0);
        tick(1);
        in_rule = 13'd7;
        #1;
        check("t2_rule7_rd", 32'(r2pg_rd), 32'd1);
        tick(1);
        in_valid = 1'b0;
        repeat (PIPE_LAT + 4) cycle(1'b0, '0, 16'h0, 1'b1, acc);
        check("t2_no_output", 32'(out_valid), 32'd0);

        // Test 3: rule 9 slots {1,2,0,4}, all lanes match -> slot 2 masked
        s = '0; s[0] = 9'd1; s[1] = 9'd2; s[3] = 9'd4; r2pg_tab[8] = s;
        pg_allow[0] = 1'b1; pg_allow[1] = 1'b1; pg_allow[3] = 1'b1; pg_allow[511] = 1'b1;
        in_valid = 1'b1; in_rule = 13'd9; in_dst_port = 16'd443; in_dst_port[0] = 1'b0; out_ready = 1'b0;
        tick(1);
        in_valid = 1'b0;
        tick(R2PG_LAT + 1);
        check("t3_req_valid", 32'(lane_req_valid), 32'b1011);
        for (int i = 0; i < PIPE_LAT + 4 && !out_valid; i++) tick(1);
        check("t3_out_valid", 32'(out_valid), 32'd1);
        check("t3_out_rule", 32'(out_rule), 32'd9);
        check("t3_out_mask", 32'(out_pg_mask), 32'b1011);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;

        // Test 4: 100 back-to-back matching rules into a stalled consumer
        s = '0; s[0] = 9'd1;
        for (int r = 100; r < 200; r++) r2pg_tab[r-1] = s;
        idx = 0;
        for (int i = 0; i < 80; i++) begin
            cycle(1'b1, RULE_AW'(100 + idx), 16'h0050, 1'b0, acc);
            if (acc) idx++;
        end
        check("t4_stored", 32'(idx), 32'(DEPTH));
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_out_valid", 32'(out_valid), 32'd1);
        guard = 0;
        while (idx < 100 && guard < 600) begin
            cycle(1'b1, RULE_AW'(100 + idx), 16'h0050, 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        check("t4_all_accepted", 32'(idx), 32'd100);
        drain("t4");

        // Test 5: random traffic, random matches, consumer ready half the time
        for (int r = 1; r < 64; r++) begin
            s = '0;
            for (int k = 0; k < NUM_PG; k++)
                s[k] = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(1, 6));
            r2pg_tab[r-1] = s;
        end
        for (int j = 0; j < 6; j++) pg_allow[j] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), RULE_AW'($urandom_range(0, 63)),
                  16'($urandom), 1'($urandom_range(0, 1)), acc);
        drain("t5");

        // Test 6: reset with 3 rules queued and 5 in flight
        pg_allow[0] = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, RULE_AW'(100 + i), 16'h0050, 1'b0, acc);
        repeat (PIPE_LAT + 2) cycle(1'b0, '0, 16'h0, 1'b0, acc);
        check("t6_queued", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, RULE_AW'(103 + i), 16'h0050, 1'b0, acc);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_in_ready", 32'(in_ready), 32'd0);
        tick(1);
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_lane_req", 32'(lane_req_valid), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_post_rst_ready", 32'(in_ready), 32'd1);
        repeat (PIPE_LAT + 6) cycle(1'b0, '0, 16'h0, 1'b1, acc);
        check("t6_no_stale", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
